// File: rtl/spi_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_arbiter
// Function : Shares one register bus between the SPI slave and an internal
//            requester. SPI has priority, with a starvation guard for the
//            internal port. Optional SPI write protection of the upper address
//            range is enabled by the macro REG_ARB_WR_PROTECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module spi_reg_arbiter #(
   parameter int                ADDR_W       = 8,
   parameter int                DATA_W       = 8,
   parameter int                RD_LATENCY   = 1,
   parameter int                STARVE_LIMIT = 4,
   parameter logic [ADDR_W-1:0] PROTECT_BASE = 'hF0
) (
   input  logic              clock_in,
   input  logic              reset_n_in,
   input  logic              spi_req,
   input  logic              spi_wr,
   input  logic [ADDR_W-1:0] spi_addr,
   input  logic [DATA_W-1:0] spi_wdata,
   output logic              spi_ack,
   output logic [DATA_W-1:0] spi_rdata,
   input  logic              int_req,
   input  logic              int_wr,
   input  logic [ADDR_W-1:0] int_addr,
   input  logic [DATA_W-1:0] int_wdata,
   output logic              int_ack,
   output logic [DATA_W-1:0] int_rdata,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   output logic              bus_wr_en,
   output logic              bus_rd_en,
   input  logic [DATA_W-1:0] bus_rd_data,
   output logic              grant_spi,
   output logic              wr_violation
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ACK   = 2'd3
   } state_t;

   localparam logic [3:0] c_wait_init    = (RD_LATENCY > 0) ? 4'(RD_LATENCY - 1) : 4'd0;
   localparam logic [7:0] c_starve_limit = 8'(STARVE_LIMIT);
`ifdef REG_ARB_WR_PROTECT_EN
   localparam bit         c_protect_en   = 1'b1;
`else
   localparam bit         c_protect_en   = 1'b0;
`endif

   state_t              r_state;
   state_t              w_state_nxt;
   logic                r_cap_spi;
   logic                r_cap_wr;
   logic [ADDR_W-1:0]   r_cap_addr;
   logic [DATA_W-1:0]   r_cap_wdata;
   logic [3:0]          r_wait_cnt;
   logic [7:0]          r_starve_cnt;
   logic                w_grant;
   logic                w_int_wins;
   logic                w_protect;
   logic                w_sample;

   // The internal port wins only when SPI is idle or the guard has tripped.
   assign w_int_wins = int_req & (~spi_req | (r_starve_cnt == c_starve_limit));
   assign w_grant    = (r_state == ST_IDLE) & (spi_req | int_req);
   assign w_protect  = c_protect_en & r_cap_spi & r_cap_wr & (r_cap_addr >= PROTECT_BASE);
   assign w_sample   = ~r_cap_wr & (((r_state == ST_ISSUE) & (RD_LATENCY == 0)) |
                                    ((r_state == ST_WAIT)  & (r_wait_cnt == 4'd0)));

   // The bus fields are the captured command, so they hold between transactions.
   assign bus_addr  = r_cap_addr;
   assign bus_wdata = r_cap_wdata;
   assign grant_spi = r_cap_spi;

   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      bus_wr_en   = 1'b0;
      bus_rd_en   = 1'b0;
      spi_ack     = 1'b0;
      int_ack     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (spi_req || int_req) begin
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            bus_wr_en = r_cap_wr & ~w_protect;
            bus_rd_en = ~r_cap_wr;
            if (r_cap_wr || (RD_LATENCY == 0)) begin
               w_state_nxt = ST_ACK;
            end else begin
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (r_wait_cnt == 4'd0) begin
               w_state_nxt = ST_ACK;
            end
         end
         ST_ACK: begin
            spi_ack     = r_cap_spi;
            int_ack     = ~r_cap_spi;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         r_cap_spi    <= 1'b0;
         r_cap_wr     <= 1'b0;
         r_cap_addr   <= '0;
         r_cap_wdata  <= '0;
         r_wait_cnt   <= 4'd0;
         r_starve_cnt <= 8'd0;
         spi_rdata    <= '0;
         int_rdata    <= '0;
      end else begin
         if (w_grant) begin
            r_cap_spi   <= ~w_int_wins;
            r_cap_wr    <= w_int_wins ? int_wr    : spi_wr;
            r_cap_addr  <= w_int_wins ? int_addr  : spi_addr;
            r_cap_wdata <= w_int_wins ? int_wdata : spi_wdata;
         end

         if (r_state == ST_ISSUE) begin
            r_wait_cnt <= c_wait_init;
         end else if ((r_state == ST_WAIT) && (r_wait_cnt != 4'd0)) begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
         end

         if (w_sample) begin
            if (r_cap_spi) begin
               spi_rdata <= bus_rd_data;
            end else begin
               int_rdata <= bus_rd_data;
            end
         end

         // Counts SPI grants that overtook a pending internal request.
         if (r_state == ST_IDLE) begin
            if (!int_req || (w_grant && w_int_wins)) begin
               r_starve_cnt <= 8'd0;
            end else if (w_grant) begin
               r_starve_cnt <= r_starve_cnt + 8'd1;
            end
         end
      end
   end

`ifdef REG_ARB_WR_PROTECT_EN
   logic r_wr_violation;

   always_ff @(posedge clock_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         r_wr_violation <= 1'b0;
      end else if ((r_state == ST_ISSUE) && w_protect) begin
         r_wr_violation <= 1'b1;
      end
   end

   assign wr_violation = r_wr_violation;
`else
   assign wr_violation = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_reg_arbiter
// Function : Directed self-checking bench for spi_reg_arbiter with a
//            scoreboard of expected completions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_reg_arbiter;

   localparam int ADDR_W       = 8;
   localparam int DATA_W       = 8;
   localparam int RD_LATENCY   = 3;
   localparam int STARVE_LIMIT = 4;
`ifdef REG_ARB_WR_PROTECT_EN
   localparam bit c_protect    = 1'b1;
`else
   localparam bit c_protect    = 1'b0;
`endif

   logic              clock_in;
   logic              reset_n_in;
   logic              spi_req;
   logic              spi_wr;
   logic [ADDR_W-1:0] spi_addr;
   logic [DATA_W-1:0] spi_wdata;
   logic              spi_ack;
   logic [DATA_W-1:0] spi_rdata;
   logic              int_req;
   logic              int_wr;
   logic [ADDR_W-1:0] int_addr;
   logic [DATA_W-1:0] int_wdata;
   logic              int_ack;
   logic [DATA_W-1:0] int_rdata;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic              bus_wr_en;
   logic              bus_rd_en;
   logic [DATA_W-1:0] bus_rd_data;
   logic              grant_spi;
   logic              wr_violation;

   spi_reg_arbiter #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .RD_LATENCY   (RD_LATENCY),
      .STARVE_LIMIT (STARVE_LIMIT),
      .PROTECT_BASE (8'hF0)
   ) dut (
      .clock_in     (clock_in),
      .reset_n_in   (reset_n_in),
      .spi_req      (spi_req),
      .spi_wr       (spi_wr),
      .spi_addr     (spi_addr),
      .spi_wdata    (spi_wdata),
      .spi_ack      (spi_ack),
      .spi_rdata    (spi_rdata),
      .int_req      (int_req),
      .int_wr       (int_wr),
      .int_addr     (int_addr),
      .int_wdata    (int_wdata),
      .int_ack      (int_ack),
      .int_rdata    (int_rdata),
      .bus_addr     (bus_addr),
      .bus_wdata    (bus_wdata),
      .bus_wr_en    (bus_wr_en),
      .bus_rd_en    (bus_rd_en),
      .bus_rd_data  (bus_rd_data),
      .grant_spi    (grant_spi),
      .wr_violation (wr_violation)
   );

   initial clock_in = 1'b0;
   always #5 clock_in = ~clock_in;

   typedef struct {
      bit         spi;
      bit         wr;
      logic [7:0] spi_rd;
      logic [7:0] int_rd;
      int         start;
      int         lat;
   } exp_t;

   exp_t       sb[$];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         cyc      = 0;
   logic [7:0] m_spi_rd = 8'h00;
   logic [7:0] m_int_rd = 8'h00;
   bit         exp_spi_order [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

   task automatic tick();
      @(posedge clock_in);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_wr_en"}, 32'(bus_wr_en), 32'd0);
      chk({tag, "_rd_en"}, 32'(bus_rd_en), 32'd0);
      chk({tag, "_spi_ack"}, 32'(spi_ack), 32'd0);
      chk({tag, "_int_ack"}, 32'(int_ack), 32'd0);
      chk({tag, "_grant"}, 32'(grant_spi), 32'd0);
      chk({tag, "_addr"}, 32'(bus_addr), 32'd0);
      chk({tag, "_wdata"}, 32'(bus_wdata), 32'd0);
      chk({tag, "_spi_rdata"}, 32'(spi_rdata), 32'd0);
      chk({tag, "_int_rdata"}, 32'(int_rdata), 32'd0);
      chk({tag, "_viol"}, 32'(wr_violation), 32'd0);
   endtask

   task automatic chk_issue(input string tag, input bit spi, input bit wr_s, input bit rd_s,
                            input logic [7:0] addr, input logic [7:0] wdata);
      chk({tag, "_wr_en"}, 32'(bus_wr_en), 32'(wr_s));
      chk({tag, "_rd_en"}, 32'(bus_rd_en), 32'(rd_s));
      chk({tag, "_addr"}, 32'(bus_addr), 32'(addr));
      chk({tag, "_wdata"}, 32'(bus_wdata), 32'(wdata));
      chk({tag, "_grant"}, 32'(grant_spi), 32'(spi));
      chk({tag, "_early_ack"}, 32'(spi_ack | int_ack), 32'd0);
   endtask

   task automatic push(input bit spi, input bit wr, input logic [7:0] rd, input int lat);
      exp_t e;
      if (!wr) begin
         if (spi) m_spi_rd = rd;
         else     m_int_rd = rd;
      end
      e.spi    = spi;
      e.wr     = wr;
      e.spi_rd = m_spi_rd;
      e.int_rd = m_int_rd;
      e.start  = cyc;
      e.lat    = lat;
      sb.push_back(e);
   endtask

   task automatic wait_ack(input string tag);
      exp_t e;
      int   n = 0;
      while (!(spi_ack || int_ack) && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_ack_seen"}, 32'(spi_ack | int_ack), 32'd1);
      chk({tag, "_pending"}, 32'(sb.size()), 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_latency"}, 32'(cyc - e.start), 32'(e.lat));
         chk({tag, "_spi_ack"}, 32'(spi_ack), 32'(e.spi));
         chk({tag, "_int_ack"}, 32'(int_ack), 32'(!e.spi));
         chk({tag, "_spi_rdata"}, 32'(spi_rdata), 32'(e.spi_rd));
         chk({tag, "_int_rdata"}, 32'(int_rdata), 32'(e.int_rd));
         chk({tag, "_grant"}, 32'(grant_spi), 32'(e.spi));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n_in  = 1'b0;
      spi_req     = 1'b0;
      spi_wr      = 1'b0;
      spi_addr    = 8'h00;
      spi_wdata   = 8'h00;
      int_req     = 1'b0;
      int_wr      = 1'b0;
      int_addr    = 8'h00;
      int_wdata   = 8'h00;
      bus_rd_data = 8'h00;
      repeat (3) tick();
      chk_zero("reset");
      reset_n_in = 1'b1;
      tick();

      // SPI write 0x12 <= 0xA5
      spi_wr = 1'b1; spi_addr = 8'h12; spi_wdata = 8'hA5; spi_req = 1'b1;
      push(1'b1, 1'b1, 8'h00, 2);
      tick();
      chk_issue("t1", 1'b1, 1'b1, 1'b0, 8'h12, 8'hA5);
      tick();
      wait_ack("t1");
      spi_req = 1'b0;
      tick();
      chk("t1_pulse", 32'(spi_ack | int_ack), 32'd0);

      // SPI read 0x40, bus returns 0x5A
      bus_rd_data = 8'h5A;
      spi_wr = 1'b0; spi_addr = 8'h40; spi_wdata = 8'h00; spi_req = 1'b1;
      push(1'b1, 1'b0, 8'h5A, 2 + RD_LATENCY);
      tick();
      chk_issue("t2", 1'b1, 1'b0, 1'b1, 8'h40, 8'h00);
      wait_ack("t2");
      spi_req = 1'b0;
      tick();

      // Internal read 0x05; data 0x3C valid only in the final wait cycle
      bus_rd_data = 8'hEE;
      int_wr = 1'b0; int_addr = 8'h05; int_wdata = 8'h00; int_req = 1'b1;
      push(1'b0, 1'b0, 8'h3C, 5);
      tick();
      chk_issue("t3", 1'b0, 1'b0, 1'b1, 8'h05, 8'h00);
      tick();
      tick();
      tick();
      bus_rd_data = 8'h3C;
      tick();
      bus_rd_data = 8'hEE;
      wait_ack("t3");
      int_req = 1'b0;
      tick();

      // Both requesters continuously re-requesting writes
      spi_wr = 1'b1; spi_addr = 8'h21; spi_wdata = 8'h11; spi_req = 1'b1;
      int_wr = 1'b1; int_addr = 8'h31; int_wdata = 8'h22; int_req = 1'b1;
      for (int k = 0; k < 6; k++) begin
         push(exp_spi_order[k], 1'b1, 8'h00, 2);
         tick();
         chk_issue($sformatf("t4_%0d", k), exp_spi_order[k], 1'b1, 1'b0,
                   exp_spi_order[k] ? 8'h21 : 8'h31, exp_spi_order[k] ? 8'h11 : 8'h22);
         tick();
         wait_ack($sformatf("t4_%0d", k));
         if (k == 5) begin
            spi_req = 1'b0;
            int_req = 1'b0;
         end
         tick();
         chk($sformatf("t4_%0d_pulse", k), 32'(spi_ack | int_ack), 32'd0);
      end

      // Reset asserted while an internal read waits for data
      bus_rd_data = 8'h77;
      int_wr = 1'b0; int_addr = 8'h07; int_wdata = 8'h00; int_req = 1'b1;
      tick();
      chk("t5_rd_en", 32'(bus_rd_en), 32'd1);
      tick();
      reset_n_in = 1'b0;
      #1;
      chk_zero("t5_rst");
      m_spi_rd = 8'h00;
      m_int_rd = 8'h00;
      tick();
      reset_n_in = 1'b1;
      push(1'b0, 1'b0, 8'h77, 5);
      tick();
      chk_issue("t5r", 1'b0, 1'b0, 1'b1, 8'h07, 8'h00);
      wait_ack("t5r");
      int_req = 1'b0;
      tick();

      // SPI fields change after the grant edge; the captured ones must be used
      spi_wr = 1'b1; spi_addr = 8'h20; spi_wdata = 8'h66; spi_req = 1'b1;
      push(1'b1, 1'b1, 8'h00, 2);
      tick();
      spi_addr = 8'h30; spi_wdata = 8'h99;
      #1;
      chk_issue("t6", 1'b1, 1'b1, 1'b0, 8'h20, 8'h66);
      tick();
      wait_ack("t6");
      chk("t6_addr_hold", 32'(bus_addr), 32'h20);
      spi_req = 1'b0;
      tick();

      // SPI write into the protected range
      spi_wr = 1'b1; spi_addr = 8'hF4; spi_wdata = 8'h5C; spi_req = 1'b1;
      push(1'b1, 1'b1, 8'h00, 2);
      tick();
      chk_issue("t7", 1'b1, !c_protect, 1'b0, 8'hF4, 8'h5C);
      tick();
      wait_ack("t7");
      chk("t7_viol", 32'(wr_violation), 32'(c_protect));
      spi_req = 1'b0;
      tick();
      chk("t7_viol_sticky", 32'(wr_violation), 32'(c_protect));

      // Internal write to the same address is never blocked
      int_wr = 1'b1; int_addr = 8'hF4; int_wdata = 8'h3A; int_req = 1'b1;
      push(1'b0, 1'b1, 8'h00, 2);
      tick();
      chk_issue("t8", 1'b0, 1'b1, 1'b0, 8'hF4, 8'h3A);
      tick();
      wait_ack("t8");
      chk("t8_viol", 32'(wr_violation), 32'(c_protect));
      int_req = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
